uart_tx_configurable: RTL and testbench

Parametrised UART transmitter for the I/O subsystem, the successor to the fixed 8N1 transmitter. It adds a transmit FIFO, runtime-selectable frame format (5–8 data bits, none/even/odd parity, 1 or 2 stop bits) and a runtime baud divisor. It sits between the memory-mapped UART registers and the serial pin.

---
 rtl/uart_tx_configurable.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_configurable.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_configurable.sv
// UART transmitter with a transmit FIFO, runtime frame format (5-8 data bits,
// none/even/odd parity, 1 or 2 stop bits) and a runtime baud divisor.
module uart_tx_configurable #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  input  logic [1:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic [DIV_WIDTH-1:0]          cfg_divisor,
  output logic                          serial_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  // state   | meaning
  // IDLE    | line high, waiting for a queued byte
  // START   | start bit (0)
  // DATA    | data bits, LSB first
  // PARITY  | parity bit, only when parity is enabled
  // STOP    | one or two stop bits (1); pops the next byte on the last cycle
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int CW          = AW + 1;
  localparam int DEFAULT_DIV = CLOCK_FREQ / BAUD_RATE;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [7:0]           fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2:0]           state_q, state_d;
  logic [7:0]           byte_q, byte_d;
  logic [1:0]           nbits_q, nbits_d;
  logic [1:0]           par_q, par_d;
  logic                 stop2_q, stop2_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] cyc_q, cyc_d;
  logic [2:0]           bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic                 serial_q, serial_d;

  logic                 push, pop, fifo_empty, bit_end, last_data, par_en;
  logic [DIV_WIDTH-1:0] d_eff;
  logic [7:0]           mask_in;

  assign data_in_ready = (count_q != FULL);
  assign push          = data_in_valid && data_in_ready;
  assign fifo_empty    = (count_q == '0);
  assign d_eff         = (div_q == '0) ? DIV_WIDTH'(1) : div_q;
  assign bit_end       = (cyc_q == d_eff - DIV_WIDTH'(1));
  assign last_data     = (bit_q == ({1'b0, nbits_q} + 3'd4));
  assign par_en        = (par_q == 2'd1) || (par_q == 2'd2);
  assign mask_in       = 8'hFF >> (2'd3 - cfg_data_bits);

  assign serial_out = serial_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign fifo_count = count_q;

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    nbits_d = nbits_q;
    par_d   = par_q;
    stop2_d = stop2_q;
    div_d   = div_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) pop = 1'b1;
      end
      S_START: begin
        cyc_d = cyc_q + DIV_WIDTH'(1);
        if (bit_end) begin
          cyc_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        cyc_d = cyc_q + DIV_WIDTH'(1);
        if (bit_end) begin
          cyc_d = '0;
          if (last_data) begin
            stop_d  = 1'b0;
            state_d = par_en ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        cyc_d = cyc_q + DIV_WIDTH'(1);
        if (bit_end) begin
          cyc_d   = '0;
          stop_d  = 1'b0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        cyc_d = cyc_q + DIV_WIDTH'(1);
        if (bit_end) begin
          cyc_d = '0;
          if (stop_q == stop2_q) begin
            if (!fifo_empty) pop = 1'b1;
            else             state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The pop edge snapshots the byte and the whole frame format.
    if (pop) begin
      byte_d  = fifo_mem_q[rd_ptr_q] & mask_in;
      nbits_d = cfg_data_bits;
      par_d   = cfg_parity;
      stop2_d = cfg_stop2;
      div_d   = cfg_divisor;
      cyc_d   = '0;
      state_d = S_START;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Line value is derived from the next state so serial_out stays registered.
  always_comb begin
    case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = byte_d[bit_d];
      S_PARITY: serial_d = (^byte_d) ^ (par_d == 2'd2);
      default:  serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      byte_q   <= '0;
      nbits_q  <= 2'd3;
      par_q    <= 2'd0;
      stop2_q  <= 1'b0;
      div_q    <= DIV_WIDTH'(DEFAULT_DIV);
      cyc_q    <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      serial_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      byte_q   <= byte_d;
      nbits_q  <= nbits_d;
      par_q    <= par_d;
      stop2_q  <= stop2_d;
      div_q    <= div_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      serial_q <= serial_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_configurable.sv
// Bench for uart_tx_configurable: expected frames are queued at push time and
// a line monitor checks every cycle of every frame against them.
module tb_uart_tx_configurable;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        data_in_valid;
  logic        data_in_ready;
  logic [1:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic [15:0] cfg_divisor;
  logic        serial_out;
  logic        tx_busy;
  logic [3:0]  fifo_count;

  uart_tx_configurable dut (
    .clk(clk), .reset(reset),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .cfg_divisor(cfg_divisor),
    .serial_out(serial_out), .tx_busy(tx_busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] seq;
    int          len;
    int          div;
  } frame_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] bits;
    logic [1:0] par;
    logic       st2;
    int         div;
    string      pat;
  } vec_t;

  frame_t exp_q[$];
  int     starts[$];
  int     checks = 0;
  int     bad = 0;
  int     cyc = 0;
  int     mon_frames = 0;
  logic   abort = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic frame_t model(input logic [7:0] b, input logic [1:0] bits,
                                   input logic [1:0] par, input logic st2, input int div);
    frame_t f;
    int n;
    logic p;
    n = 5 + int'(bits);
    f.seq = '1;
    f.len = 0;
    f.seq[f.len] = 1'b0; f.len++;
    p = 1'b0;
    for (int i = 0; i < n; i++) begin
      f.seq[f.len] = b[i]; p ^= b[i]; f.len++;
    end
    if (par == 2'd1)      begin f.seq[f.len] = p;  f.len++; end
    else if (par == 2'd2) begin f.seq[f.len] = ~p; f.len++; end
    f.seq[f.len] = 1'b1; f.len++;
    if (st2) begin f.seq[f.len] = 1'b1; f.len++; end
    f.div = (div < 1) ? 1 : div;
    return f;
  endfunction

  task automatic add_exp(input logic [7:0] b, input logic [1:0] bits,
                         input logic [1:0] par, input logic st2, input int div);
    exp_q.push_back(model(b, bits, par, st2, div));
  endtask

  task automatic add_exp_pat(input string pat, input int div);
    frame_t f;
    f.seq = '1;
    f.len = pat.len();
    for (int i = 0; i < pat.len(); i++) f.seq[i] = (pat[i] == "1");
    f.div = (div < 1) ? 1 : div;
    exp_q.push_back(f);
  endtask

  task automatic set_cfg(input logic [1:0] bits, input logic [1:0] par,
                         input logic st2, input int div);
    cfg_data_bits = bits;
    cfg_parity    = par;
    cfg_stop2     = st2;
    cfg_divisor   = 16'(div);
  endtask

  task automatic push_one(input logic [7:0] b);
    @(negedge clk);
    data_in = b; data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (mon_frames < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (mon_frames < target) begin
      checks++; bad++;
      $display("FAIL wait_frames: got %0d frames expected %0d within %0d cycles", mon_frames, target, budget);
    end
  endtask

  // Line monitor: a falling edge on an idle line starts the next expected frame.
  frame_t m_rec;
  logic   m_ok, m_first, m_abort, m_val;
  int     m_bit;
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && !abort && serial_out === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++; bad++;
          $display("FAIL unexpected_start: serial_out=0 at cycle %0d, expected idle line", cyc);
        end else begin
          m_rec = exp_q.pop_front();
          starts.push_back(cyc);
          m_ok = 1'b1; m_first = 1'b1; m_abort = 1'b0; m_bit = 0; m_val = 1'b0;
          for (int b = 0; b < m_rec.len; b++) begin
            for (int c = 0; c < m_rec.div; c++) begin
              if (!m_first && !m_abort) begin
                @(negedge clk);
                if (abort) m_abort = 1'b1;
              end
              m_first = 1'b0;
              if (!m_abort && (serial_out !== m_rec.seq[b] || tx_busy !== 1'b1)) begin
                if (m_ok) begin m_bit = b; m_val = serial_out; end
                m_ok = 1'b0;
              end
            end
          end
          if (!m_abort) begin
            checks++;
            if (!m_ok) begin
              bad++;
              $display("FAIL frame: bit %0d got %b expected %b (busy=%b) frame_start=%0d",
                       m_bit, m_val, m_rec.seq[m_bit], tx_busy, starts[starts.size()-1]);
            end
            mon_frames++;
          end
        end
      end
    end
  end

  vec_t vecs[7];
  int   base, trans;

  initial begin
    vecs[0] = '{8'hA5, 2'd3, 2'd0, 1'b0, 4, "0101001011"};
    vecs[1] = '{8'hC1, 2'd2, 2'd1, 1'b0, 3, "0100000101"};
    vecs[2] = '{8'h1F, 2'd0, 2'd2, 1'b1, 2, "011111011"};
    vecs[3] = '{8'hC3, 2'd1, 2'd0, 1'b0, 1, "01100001"};
    vecs[4] = '{8'h00, 2'd3, 2'd2, 1'b0, 0, "00000000011"};
    vecs[5] = '{8'h81, 2'd3, 2'd1, 1'b1, 2, "010000001011"};
    vecs[6] = '{8'hF5, 2'd0, 2'd3, 1'b0, 3, "0101011"};

    reset = 1'b1; data_in = 8'h00; data_in_valid = 1'b0;
    set_cfg(2'd3, 2'd0, 1'b0, 4);
    repeat (3) @(negedge clk);
    chk("rst_serial", 32'(serial_out), 1);
    chk("rst_busy", 32'(tx_busy), 0);
    chk("rst_ready", 32'(data_in_ready), 1);
    chk("rst_count", 32'(fifo_count), 0);
    reset = 1'b0;
    @(negedge clk);

    // Accept at edge N, pop at N+1, line falls after N+1.
    base = mon_frames;
    add_exp(8'h5A, 2'd3, 2'd0, 1'b0, 4);
    data_in = 8'h5A; data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    chk("lat_count_N", 32'(fifo_count), 1);
    chk("lat_line_N", 32'(serial_out), 1);
    chk("lat_busy_N", 32'(tx_busy), 0);
    @(negedge clk);
    chk("lat_count_N1", 32'(fifo_count), 0);
    chk("lat_line_N1", 32'(serial_out), 0);
    chk("lat_busy_N1", 32'(tx_busy), 1);
    wait_frames(base + 1, 200);

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      set_cfg(vecs[i].bits, vecs[i].par, vecs[i].st2, vecs[i].div);
      base = mon_frames;
      add_exp_pat(vecs[i].pat, vecs[i].div);
      push_one(vecs[i].data);
      wait_frames(base + 1, 500);
      @(negedge clk);
      chk("vec_idle_busy", 32'(tx_busy), 0);
      chk("vec_idle_line", 32'(serial_out), 1);
      chk("vec_idle_count", 32'(fifo_count), 0);
    end

    // Ten push attempts at divisor 1: nine fit, the tenth sees a full FIFO.
    @(negedge clk);
    set_cfg(2'd3, 2'd0, 1'b0, 1);
    starts.delete();
    base = mon_frames;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("b2b_ready", 32'(data_in_ready), (k < 9) ? 1 : 0);
      if (k == 9) chk("b2b_count_full", 32'(fifo_count), 8);
      data_in = 8'(8'h30 + 8'(k * 17));
      data_in_valid = 1'b1;
      if (k < 9) add_exp(data_in, 2'd3, 2'd0, 1'b0, 1);
    end
    @(negedge clk);
    data_in_valid = 1'b0;
    wait_frames(base + 9, 300);
    repeat (3) @(negedge clk);
    chk("b2b_frames", 32'(starts.size()), 9);
    for (int j = 1; j < starts.size(); j++)
      chk("b2b_gap", 32'(starts[j] - starts[j-1]), 10);
    chk("b2b_count_end", 32'(fifo_count), 0);
    chk("b2b_busy_end", 32'(tx_busy), 0);

    // Config change mid-frame applies only to the following frame.
    set_cfg(2'd3, 2'd0, 1'b0, 4);
    starts.delete();
    base = mon_frames;
    add_exp(8'h3C, 2'd3, 2'd0, 1'b0, 4);
    add_exp(8'h96, 2'd0, 2'd1, 1'b0, 8);
    @(negedge clk); data_in = 8'h3C; data_in_valid = 1'b1;
    @(negedge clk); data_in = 8'h96;
    @(negedge clk); data_in_valid = 1'b0;
    repeat (16) @(negedge clk);
    cfg_divisor = 16'd8; cfg_data_bits = 2'd0; cfg_parity = 2'd1;
    wait_frames(base + 2, 400);
    if (starts.size() >= 2) chk("cfg_gap", 32'(starts[1] - starts[0]), 40);
    else chk("cfg_frames", 32'(starts.size()), 2);

    // Reset pulse in the middle of the data bits with three bytes still queued.
    @(negedge clk);
    set_cfg(2'd3, 2'd0, 1'b0, 4);
    for (int k = 0; k < 4; k++) add_exp(8'(8'hE0 + k), 2'd3, 2'd0, 1'b0, 4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); data_in = 8'(8'hE0 + k); data_in_valid = 1'b1;
    end
    @(negedge clk); data_in_valid = 1'b0;
    chk("rst_mid_count_before", 32'(fifo_count), 3);
    repeat (14) @(negedge clk);
    abort = 1'b1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_line", 32'(serial_out), 1);
    chk("rst_mid_count", 32'(fifo_count), 0);
    chk("rst_mid_ready", 32'(data_in_ready), 1);
    chk("rst_mid_busy", 32'(tx_busy), 0);
    exp_q.delete();
    trans = 0;
    repeat (60) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || tx_busy !== 1'b0) trans++;
    end
    chk("rst_mid_quiet", 32'(trans), 0);
    abort = 1'b0;

    // A few randomised single frames to cover other format mixes.
    for (int r = 0; r < 6; r++) begin
      logic [7:0] b;
      logic [1:0] nb, pm;
      logic       s2;
      int         dv;
      b  = 8'($urandom_range(0, 255));
      nb = 2'($urandom_range(0, 3));
      pm = 2'($urandom_range(0, 3));
      s2 = 1'($urandom_range(0, 1));
      dv = $urandom_range(1, 3);
      @(negedge clk);
      set_cfg(nb, pm, s2, dv);
      base = mon_frames;
      add_exp(b, nb, pm, s2, dv);
      push_one(b);
      wait_frames(base + 1, 200);
      @(negedge clk);
      chk("rand_idle_busy", 32'(tx_busy), 0);
    end

    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end

endmodule
